qsys_cpu_oci_dct_sequencer: RTL and testbench

- Capture sequencer for the OCI data-capture-trace (DCT) path.
- Packs 2-bit trace symbols into the 30-bit dct_buffer and tracks the symbol count in dct_count.
- Hands completed or partial frames to a downstream trace sink over a valid/ready handshake.
- Sequences end-of-test flush: test_ending → drain → test_has_ended, the signals consumed by the OCI test bench.

---
 rtl/qsys_cpu_oci_dct_sequencer.sv | 103 ++++++++++
 tb/tb_qsys_cpu_oci_dct_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_cpu_oci_dct_sequencer.sv
// OCI data-capture-trace sequencer: packs trace symbols into a frame buffer,
// hands frames to the trace sink over valid/ready, and sequences the end-of-test flush.
module qsys_cpu_oci_dct_sequencer #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 15,
  parameter int CNT_W = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           trace_en,
  input  logic                           sym_valid,
  input  logic [SYM_W-1:0]               sym_data,
  input  logic                           test_ending,
  input  logic                           frm_ready,
  input  logic                           clr_overflow,
  output logic [SYM_W*DEPTH-1:0]         dct_buffer,
  output logic [CNT_W-1:0]               dct_count,
  output logic                           frm_valid,
  output logic [CNT_W+SYM_W*DEPTH-1:0]   frm_data,
  output logic                           overflow,
  output logic                           test_has_ended,
  output logic                           busy
);

  localparam int BUF_W = SYM_W * DEPTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t state;

  logic             load_trig;
  logic             out_free;
  logic             load;
  logic             accept;
  logic             drop;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] cnt_nx;
  logic [BUF_W-1:0] buf_nx;

  // A full buffer, or any residue during flush, moves to the output register
  // whenever that register is empty or being drained this same cycle.
  assign load_trig = (dct_count == FULL) || ((state == FLUSH) && (dct_count != '0));
  assign out_free  = !frm_valid || frm_ready;
  assign load      = load_trig && out_free;
  assign accept    = (state == CAPTURE) && sym_valid && ((dct_count < FULL) || load);
  assign drop      = (state == CAPTURE) && sym_valid && !accept;
  assign wr_idx    = load ? '0 : dct_count;

  always_comb begin
    buf_nx = load ? '0 : dct_buffer;
    if (accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_idx == CNT_W'(k)) buf_nx[SYM_W*k +: SYM_W] = sym_data;
      end
    end
  end

  always_comb begin
    if (accept)    cnt_nx = wr_idx + CNT_W'(1);
    else if (load) cnt_nx = '0;
    else           cnt_nx = dct_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      dct_buffer     <= '0;
      dct_count      <= '0;
      frm_data       <= '0;
      frm_valid      <= 1'b0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      dct_buffer <= buf_nx;
      dct_count  <= cnt_nx;
      if (load) frm_data <= {dct_count, dct_buffer};
      frm_valid  <= load || (frm_valid && !frm_ready);
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;

      case (state)
        IDLE: if (trace_en) state <= CAPTURE;
        CAPTURE: if (test_ending || !trace_en) state <= FLUSH;
        FLUSH: begin
          if ((dct_count == '0) && !frm_valid) begin
            state          <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        DONE: begin
          if (!trace_en && !test_ending) begin
            state          <= IDLE;
            test_has_ended <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == FLUSH) || frm_valid || (dct_count != '0);

endmodule

// File: tb/tb_qsys_cpu_oci_dct_sequencer.sv
// Bench for qsys_cpu_oci_dct_sequencer: vector table for the basic fill, frame
// scoreboard on the sink side, and hand-written flush/back-pressure/reset sequences.
module tb_qsys_cpu_oci_dct_sequencer;

  logic        clk;
  logic        reset_n;
  logic        trace_en;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        test_ending;
  logic        frm_ready;
  logic        clr_overflow;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frm_valid;
  logic [33:0] frm_data;
  logic        overflow;
  logic        test_has_ended;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];

  qsys_cpu_oci_dct_sequencer #(.SYM_W(2), .DEPTH(15), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .sym_valid(sym_valid),
    .sym_data(sym_data), .test_ending(test_ending), .frm_ready(frm_ready),
    .clr_overflow(clr_overflow), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .frm_valid(frm_valid), .frm_data(frm_data), .overflow(overflow),
    .test_has_ended(test_has_ended), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        te;
    logic        sv;
    logic [1:0]  sd;
    logic        rdy;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_vld;
    logic        e_ovf;
    logic        e_end;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink side: every transfer must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && frm_valid && frm_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%0h exp=none", frm_data);
      end else begin
        chk("sb_frame", 64'(frm_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    trace_en = 1'b0; sym_valid = 1'b0; sym_data = 2'd0;
    test_ending = 1'b0; frm_ready = 1'b0; clr_overflow = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [29:0] acc;
  logic [29:0] acc2;
  logic [1:0]  d;

  initial begin
    // Vector table for the basic fill with an always-ready sink.
    acc = '0;
    vt[0] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 15; k++) begin
      d = 2'(k % 4);
      acc = acc | (30'(d) << (2 * k));
      vt[k+1] = '{1'b1, 1'b1, d, 1'b1, 4'(k + 1), acc, 1'b0, 1'b0, 1'b0};
    end
    vt[16] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b0, 2'd0, 1'b1, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0};

    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(dct_count), 64'd0);
    chk("rst_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_frm_valid", 64'(frm_valid), 64'd0);
    chk("rst_frm_data", 64'(frm_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_ended", 64'(test_has_ended), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;

    // Fill: 15 symbols 0..3 repeating
    for (int i = 0; i < 18; i++) begin
      trace_en = vt[i].te; sym_valid = vt[i].sv; sym_data = vt[i].sd; frm_ready = vt[i].rdy;
      tick();
      chk($sformatf("fill_cnt_%0d", i), 64'(dct_count), 64'(vt[i].e_cnt));
      chk($sformatf("fill_buf_%0d", i), 64'(dct_buffer), 64'(vt[i].e_buf));
      chk($sformatf("fill_vld_%0d", i), 64'(frm_valid), 64'(vt[i].e_vld));
      chk($sformatf("fill_ovf_%0d", i), 64'(overflow), 64'(vt[i].e_ovf));
      chk($sformatf("fill_end_%0d", i), 64'(test_has_ended), 64'(vt[i].e_end));
      if (i == 15) sb.push_back({4'd15, 30'h24E4E4E4});
    end

    // Back-pressure: 31 symbols into a stalled sink
    frm_ready = 1'b0;
    acc = '0;
    for (int k = 0; k < 15; k++) begin
      d = 2'((k + 1) % 4);
      acc = acc | (30'(d) << (2 * k));
      sym_valid = 1'b1; sym_data = d;
      tick();
    end
    sb.push_back({4'd15, acc});
    chk("bp_count15", 64'(dct_count), 64'd15);
    acc2 = '0;
    for (int k = 0; k < 15; k++) begin
      d = 2'(3 - (k % 4));
      acc2 = acc2 | (30'(d) << (2 * k));
      sym_data = d;
      tick();
      if (k == 0) begin
        chk("bp_load_vld", 64'(frm_valid), 64'd1);
        chk("bp_load_cnt", 64'(dct_count), 64'd1);
      end
    end
    sym_data = 2'd1; clr_overflow = 1'b1;
    tick();
    chk("bp_ovf_set_wins", 64'(overflow), 64'd1);
    chk("bp_cnt_held", 64'(dct_count), 64'd15);
    chk("bp_buf_held", 64'(dct_buffer), 64'(acc2));
    chk("bp_frame_stable", 64'(frm_data), 64'({4'd15, acc}));
    chk("bp_vld_held", 64'(frm_valid), 64'd1);
    sym_valid = 1'b0;
    tick();
    chk("bp_ovf_clr", 64'(overflow), 64'd0);
    clr_overflow = 1'b0;

    // Same-cycle reload: drain frame 1, load frame 2 and take a new symbol
    sb.push_back({4'd15, acc2});
    frm_ready = 1'b1; sym_valid = 1'b1; sym_data = 2'd2;
    tick();
    sym_valid = 1'b0; frm_ready = 1'b0;
    chk("rl_vld", 64'(frm_valid), 64'd1);
    chk("rl_data", 64'(frm_data), 64'({4'd15, acc2}));
    chk("rl_cnt", 64'(dct_count), 64'd1);
    chk("rl_buf", 64'(dct_buffer), 64'd2);
    tick();
    chk("rl_hold", 64'(frm_data), 64'({4'd15, acc2}));
    frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;
    chk("rl_drained", 64'(frm_valid), 64'd0);
    chk("rl_cnt_keep", 64'(dct_count), 64'd1);

    // Partial flush: 5 symbols, test_ending on the last one
    do_reset();
    trace_en = 1'b1; frm_ready = 1'b1;
    tick();
    sym_valid = 1'b1;
    sym_data = 2'd3; tick();
    sym_data = 2'd1; tick();
    sym_data = 2'd2; tick();
    sym_data = 2'd0; tick();
    sym_data = 2'd3; test_ending = 1'b1;
    sb.push_back({4'd5, 30'h327});
    tick();
    sym_valid = 1'b0;
    chk("pf_cnt", 64'(dct_count), 64'd5);
    chk("pf_buf", 64'(dct_buffer), 64'h327);
    chk("pf_end0", 64'(test_has_ended), 64'd0);
    chk("pf_busy0", 64'(busy), 64'd1);
    tick();
    chk("pf_vld", 64'(frm_valid), 64'd1);
    chk("pf_cnt0", 64'(dct_count), 64'd0);
    tick();
    chk("pf_vld_drop", 64'(frm_valid), 64'd0);
    chk("pf_end1", 64'(test_has_ended), 64'd0);
    chk("pf_busy_flush", 64'(busy), 64'd1);
    tick();
    chk("pf_ended", 64'(test_has_ended), 64'd1);
    chk("pf_busy_done", 64'(busy), 64'd0);
    sym_valid = 1'b1;
    tick();
    chk("pf_done_ignore_ovf", 64'(overflow), 64'd0);
    chk("pf_done_ignore_cnt", 64'(dct_count), 64'd0);
    chk("pf_done_hold", 64'(test_has_ended), 64'd1);
    sym_valid = 1'b0; trace_en = 1'b0; test_ending = 1'b0;
    tick();
    chk("pf_idle", 64'(test_has_ended), 64'd0);
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    chk("pf_idle_ignore_cnt", 64'(dct_count), 64'd0);
    chk("pf_idle_ignore_ovf", 64'(overflow), 64'd0);

    // Empty flush
    trace_en = 1'b1;
    tick();
    test_ending = 1'b1;
    tick();
    chk("ef_end0", 64'(test_has_ended), 64'd0);
    chk("ef_vld0", 64'(frm_valid), 64'd0);
    tick();
    chk("ef_end1", 64'(test_has_ended), 64'd1);
    chk("ef_vld1", 64'(frm_valid), 64'd0);
    trace_en = 1'b0; test_ending = 1'b0;
    tick();
    chk("ef_idle", 64'(test_has_ended), 64'd0);

    // Mid-operation asynchronous reset with a pending frame and 7 symbols held
    trace_en = 1'b1; frm_ready = 1'b0;
    tick();
    sym_valid = 1'b1; sym_data = 2'd1;
    for (int k = 0; k < 15; k++) tick();
    sym_valid = 1'b0;
    tick();
    sym_valid = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    sym_valid = 1'b0;
    chk("mr_pre_cnt", 64'(dct_count), 64'd7);
    chk("mr_pre_vld", 64'(frm_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_cnt", 64'(dct_count), 64'd0);
    chk("mr_buf", 64'(dct_buffer), 64'd0);
    chk("mr_vld", 64'(frm_valid), 64'd0);
    chk("mr_data", 64'(frm_data), 64'd0);
    chk("mr_ovf", 64'(overflow), 64'd0);
    chk("mr_end", 64'(test_has_ended), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    trace_en = 1'b0;
    tick();
    reset_n = 1'b1;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    chk("mr_idle_cnt", 64'(dct_count), 64'd0);
    chk("mr_idle_end", 64'(test_has_ended), 64'd0);

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
